// File: rtl/data_sender_pkg.sv
// Shared types and defaults for the data_sender byte serialiser.
package data_sender_pkg;
  localparam int DATA_BYTES_DEF = 5;
  localparam int BYTE_W_DEF     = 8;
  localparam int IDX_W          = $clog2(DATA_BYTES_DEF);

  typedef logic [BYTE_W_DEF-1:0] byte_t;
endpackage

// File: rtl/data_sender_idx_ctr.sv
// Byte index counter for data_sender. Build with DATA_SENDER_WRAP_EN to wrap
// back to byte 0 after the last byte; by default it parks on the last byte.
module data_sender_idx_ctr #(
  parameter int DEPTH = 5,
  parameter int IW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [IW-1:0] idx
);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [IW-1:0] idx_nxt;

  // A restart wins over a simultaneous advance.
  always_comb begin
    idx_nxt = idx;
    if (clr)
      idx_nxt = '0;
    else if (adv && idx != LAST)
      idx_nxt = idx + 1'b1;
`ifdef DATA_SENDER_WRAP_EN
    else if (adv)
      idx_nxt = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx <= '0;
    else     idx <= idx_nxt;
  end
endmodule

// File: rtl/data_sender.sv
// Latches a wide word on transmissionStart and offers it LSB-first, one byte
// per transmissionDone. End-of-word wrap is enabled by DATA_SENDER_WRAP_EN.
module data_sender
  import data_sender_pkg::*;
#(
  parameter int DATA_BYTES = DATA_BYTES_DEF,
  parameter int BYTE_W     = BYTE_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_BYTES*BYTE_W-1:0] dataIn,
  input  logic                         transmissionStart,
  input  logic                         transmissionDone,
  output logic [BYTE_W-1:0]            dataOut
);
  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  logic [DATA_BYTES-1:0][BYTE_W-1:0] hold_reg;
  logic [IW-1:0]                     idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    hold_reg <= '0;
    else if (transmissionStart) hold_reg <= dataIn;
  end

  data_sender_idx_ctr #(.DEPTH(DATA_BYTES), .IW(IW)) u_idx_ctr (
    .clk (clk),
    .rst (rst),
    .clr (transmissionStart),
    .adv (transmissionDone),
    .idx (idx)
  );

  // idx never exceeds DATA_BYTES-1, so the select stays in range.
  assign dataOut = hold_reg[idx];
endmodule

// File: tb/tb_data_sender.sv
// Self-checking bench for data_sender: directed scenarios then random traffic
// against a word/position reference model.
module tb_data_sender;
  localparam int NB = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NB*8-1:0] dataIn = '0;
  logic            transmissionStart = 1'b0;
  logic            transmissionDone  = 1'b0;
  logic [7:0]      dataOut;

  int passed = 0;
  int total  = 0;

  logic [NB*8-1:0] m_word = '0;
  int              m_pos  = 0;

  data_sender dut (
    .clk               (clk),
    .rst               (rst),
    .dataIn            (dataIn),
    .transmissionStart (transmissionStart),
    .transmissionDone  (transmissionDone),
    .dataOut           (dataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_byte();
    logic [NB*8-1:0] sh;
    sh = m_word >> (8 * m_pos);
    return sh[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: dataOut=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: apply inputs, take the edge, update the model, sample 1ns later.
  task automatic step(input string tag, input bit s, input bit d, input logic [NB*8-1:0] din);
    transmissionStart = s;
    transmissionDone  = d;
    dataIn            = din;
    @(posedge clk);
    if (s) begin
      m_word = din;
      m_pos  = 0;
    end else if (d) begin
      if (m_pos < NB - 1) m_pos++;
`ifdef DATA_SENDER_WRAP_EN
      else m_pos = 0;
`endif
    end
    #1;
    check(tag, dataOut, m_byte());
  endtask

  task automatic async_reset(input string tag);
    transmissionStart = 1'b0;
    transmissionDone  = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_word = '0;
    m_pos  = 0;
    check(tag, dataOut, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    check({tag, "_hold"}, dataOut, 8'h00);
  endtask

  initial begin
    logic [NB*8-1:0] w;
    bit s, d;

    rst = 1'b1;
    #1;
    check("reset", dataOut, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic LSB-first sequence.
    step("start0", 1, 0, 40'h1122334455);
    check("start0_lit", dataOut, 8'h55);
    for (int i = 0; i < 4; i++) step("seq0", 0, 1, 40'h0);
    check("seq0_last", dataOut, 8'h11);

    // Extra done after the last byte.
    step("extra_done", 0, 1, 40'h0);
`ifdef DATA_SENDER_WRAP_EN
    check("extra_done_lit", dataOut, 8'h55);
`else
    check("extra_done_lit", dataOut, 8'h11);
`endif

    // Mid-sequence reset at idx=4.
    step("start1", 1, 0, 40'h1122334455);
    for (int i = 0; i < 4; i++) step("seq1", 0, 1, 40'h0);
    async_reset("midreset");

    // dataIn changes after start must not matter.
    step("start2", 1, 0, 40'h1122334455);
    for (int i = 0; i < 4; i++) step("din_chg", 0, 1, 40'h1234123412);
    check("din_chg_lit", dataOut, 8'h11);

    // Restart while parked on the last byte.
    step("restart", 1, 0, 40'h1234123412);
    check("restart_lit", dataOut, 8'h12);
    for (int i = 0; i < 4; i++) step("seq3", 0, 1, 40'h0);

    // Start and done in the same cycle: start wins.
    step("start_done", 1, 1, 40'hAABBCCDDEE);
    check("start_done_lit", dataOut, 8'hEE);

    // Done held for three cycles advances three bytes.
    step("start4", 1, 0, 40'h1122334455);
    for (int i = 0; i < 3; i++) step("held_done", 0, 1, 40'h0);
    check("held_done_lit", dataOut, 8'h22);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd_reset");
      end else begin
        w = {$urandom(), $urandom()};
        s = ($urandom_range(0, 7) == 0);
        d = ($urandom_range(0, 1) == 1);
        step("rnd", s, d, w);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end
endmodule
